// File: rtl/axi_timer_multi.sv
// Multi-channel timer/compare peripheral behind an AXI4-Lite slave port.
// Each channel: prescaler, up-counter, compare, one-shot mode; sticky W1C status with level IRQs.

module axi_timer_multi_ch #(
  parameter int unsigned CNT_BW_p   = 32,
  parameter int unsigned PRESC_BW_p = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [1:0]            i_wr_off,
  input  logic [31:0]           i_wdata,
  output logic                  o_en,
  output logic                  o_oneshot,
  output logic                  o_irq_en,
  output logic [PRESC_BW_p-1:0] o_presc,
  output logic [CNT_BW_p-1:0]   o_cmp,
  output logic [CNT_BW_p-1:0]   o_cnt,
  output logic                  o_match
);

  localparam logic [CNT_BW_p-1:0]   CNT_ONE   = CNT_BW_p'(1);
  localparam logic [PRESC_BW_p-1:0] PRESC_ONE = PRESC_BW_p'(1);

  logic                  r_en;
  logic                  r_oneshot;
  logic                  r_irq_en;
  logic [PRESC_BW_p-1:0] r_presc;
  logic [PRESC_BW_p-1:0] r_pcnt;
  logic [CNT_BW_p-1:0]   r_cmp;
  logic [CNT_BW_p-1:0]   r_cnt;

  logic w_tick;
  logic w_cnt_wr;
  logic w_match;
  logic w_unused_wdata;

  assign w_unused_wdata = ^i_wdata;

  // A software COUNT write suppresses match evaluation in the same cycle.
  always_comb begin
    w_tick   = r_en && (r_pcnt == r_presc);
    w_cnt_wr = i_wr && (i_wr_off == 2'd3);
    w_match  = w_tick && (r_cnt == r_cmp) && !w_cnt_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_irq_en  <= 1'b0;
      r_presc   <= '0;
      r_pcnt    <= '0;
      r_cmp     <= '0;
      r_cnt     <= '0;
    end else begin
      if (r_en) begin
        if (w_tick) begin
          r_pcnt <= '0;
          if (w_match) begin
            r_cnt <= '0;
            if (r_oneshot) begin
              r_en <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end else begin
          r_pcnt <= r_pcnt + PRESC_ONE;
        end
      end
      // Register writes come last so software values override timer updates.
      if (i_wr) begin
        case (i_wr_off)
          2'd0: begin
            r_en      <= i_wdata[0];
            r_oneshot <= i_wdata[1];
            r_irq_en  <= i_wdata[2];
            if (i_wdata[0] && !r_en) begin
              r_pcnt <= '0;
            end
          end
          2'd1:    r_presc <= i_wdata[PRESC_BW_p-1:0];
          2'd2:    r_cmp   <= i_wdata[CNT_BW_p-1:0];
          default: r_cnt   <= i_wdata[CNT_BW_p-1:0];
        endcase
      end
    end
  end

  assign o_en      = r_en;
  assign o_oneshot = r_oneshot;
  assign o_irq_en  = r_irq_en;
  assign o_presc   = r_presc;
  assign o_cmp     = r_cmp;
  assign o_cnt     = r_cnt;
  assign o_match   = w_match;

endmodule

module axi_timer_multi #(
  parameter int unsigned CH_NBR_p      = 4,
  parameter int unsigned AXI_ADDR_BW_p = 12,
  parameter int unsigned CNT_BW_p      = 32,
  parameter int unsigned PRESC_BW_p    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  output logic                     o_axi_awready,
  input  logic [31:0]              i_axi_wdata,
  input  logic                     i_axi_wvalid,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_axi_rready,
  output logic [CH_NBR_p-1:0]      o_irq_ch,
  output logic                     o_irq
);

  localparam logic [AXI_ADDR_BW_p-1:0] STATUS_ADDR = AXI_ADDR_BW_p'(32'h100);
  localparam logic [1:0]               RESP_OKAY   = 2'b00;
  localparam logic [1:0]               RESP_SLVERR = 2'b10;

  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [31:0]         r_rdata;
  logic [CH_NBR_p-1:0] r_status;

  logic                w_wr_fire;
  logic                w_rd_fire;
  logic [CH_NBR_p-1:0] w_wr_ch_hit;
  logic [CH_NBR_p-1:0] w_rd_ch_hit;
  logic                w_wr_status;
  logic                w_rd_status;
  logic                w_wr_err;
  logic                w_rd_err;
  logic [31:0]         w_rd_data;
  logic [CH_NBR_p-1:0] w_status_clr;
  logic                w_unused_addr;

  logic [CH_NBR_p-1:0]   w_en;
  logic [CH_NBR_p-1:0]   w_oneshot;
  logic [CH_NBR_p-1:0]   w_irq_en;
  logic [CH_NBR_p-1:0]   w_match;
  logic [PRESC_BW_p-1:0] w_presc [CH_NBR_p];
  logic [CNT_BW_p-1:0]   w_cmp   [CH_NBR_p];
  logic [CNT_BW_p-1:0]   w_cnt   [CH_NBR_p];

  assign w_unused_addr = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

  assign w_wr_fire = i_axi_awvalid && i_axi_wvalid && !r_bvalid;
  assign w_rd_fire = i_axi_arvalid && !r_rvalid;

  // Channel windows occupy 0x000..0x0FF at 16-byte stride; STATUS sits alone at 0x100.
  always_comb begin
    w_wr_ch_hit = '0;
    w_rd_ch_hit = '0;
    for (int unsigned c = 0; c < CH_NBR_p; c++) begin
      w_wr_ch_hit[c] = (i_axi_awaddr[AXI_ADDR_BW_p-1:8] == '0) && (i_axi_awaddr[7:4] == 4'(c));
      w_rd_ch_hit[c] = (i_axi_araddr[AXI_ADDR_BW_p-1:8] == '0) && (i_axi_araddr[7:4] == 4'(c));
    end
    w_wr_status = ({i_axi_awaddr[AXI_ADDR_BW_p-1:2], 2'b00} == STATUS_ADDR);
    w_rd_status = ({i_axi_araddr[AXI_ADDR_BW_p-1:2], 2'b00} == STATUS_ADDR);
    w_wr_err    = !(w_wr_status || (|w_wr_ch_hit));
    w_rd_err    = !(w_rd_status || (|w_rd_ch_hit));
  end

  for (genvar g = 0; g < CH_NBR_p; g++) begin : g_ch
    axi_timer_multi_ch #(
      .CNT_BW_p   (CNT_BW_p),
      .PRESC_BW_p (PRESC_BW_p)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr_fire && w_wr_ch_hit[g]),
      .i_wr_off  (i_axi_awaddr[3:2]),
      .i_wdata   (i_axi_wdata),
      .o_en      (w_en[g]),
      .o_oneshot (w_oneshot[g]),
      .o_irq_en  (w_irq_en[g]),
      .o_presc   (w_presc[g]),
      .o_cmp     (w_cmp[g]),
      .o_cnt     (w_cnt[g]),
      .o_match   (w_match[g])
    );
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_status) begin
      w_rd_data = 32'(r_status);
    end
    for (int unsigned c = 0; c < CH_NBR_p; c++) begin
      if (w_rd_ch_hit[c]) begin
        case (i_axi_araddr[3:2])
          2'd0:    w_rd_data = {29'd0, w_irq_en[c], w_oneshot[c], w_en[c]};
          2'd1:    w_rd_data = 32'(w_presc[c]);
          2'd2:    w_rd_data = 32'(w_cmp[c]);
          default: w_rd_data = 32'(w_cnt[c]);
        endcase
      end
    end
  end

  assign w_status_clr = (w_wr_fire && w_wr_status) ? i_axi_wdata[CH_NBR_p-1:0] : '0;

  // A match in the same cycle as W1C keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | w_match;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_bvalid && i_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && i_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_axi_awready = w_wr_fire;
  assign o_axi_wready  = w_wr_fire;
  assign o_axi_bvalid  = r_bvalid;
  assign o_axi_bresp   = r_bresp;
  assign o_axi_arready = w_rd_fire;
  assign o_axi_rvalid  = r_rvalid;
  assign o_axi_rresp   = r_rresp;
  assign o_axi_rdata   = r_rdata;
  assign o_irq_ch      = r_status & w_irq_en;
  assign o_irq         = |o_irq_ch;

endmodule

// File: tb/tb_axi_timer_multi.sv
// Directed bench for axi_timer_multi: timing, one-shot, W1C races, decode errors,
// AXI backpressure, counter wrap and mid-transaction reset.

module tb_axi_timer_multi;

  logic        clk;
  logic        rst;
  logic [11:0] i_axi_awaddr;
  logic        i_axi_awvalid;
  logic        o_axi_awready;
  logic [31:0] i_axi_wdata;
  logic        i_axi_wvalid;
  logic        o_axi_wready;
  logic [1:0]  o_axi_bresp;
  logic        o_axi_bvalid;
  logic        i_axi_bready;
  logic [11:0] i_axi_araddr;
  logic        i_axi_arvalid;
  logic        o_axi_arready;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp;
  logic        o_axi_rvalid;
  logic        i_axi_rready;
  logic [3:0]  o_irq_ch;
  logic        o_irq;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  axi_timer_multi #(
    .CH_NBR_p      (4),
    .AXI_ADDR_BW_p (12),
    .CNT_BW_p      (32),
    .PRESC_BW_p    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_axi_awaddr  (i_axi_awaddr),
    .i_axi_awvalid (i_axi_awvalid),
    .o_axi_awready (o_axi_awready),
    .i_axi_wdata   (i_axi_wdata),
    .i_axi_wvalid  (i_axi_wvalid),
    .o_axi_wready  (o_axi_wready),
    .o_axi_bresp   (o_axi_bresp),
    .o_axi_bvalid  (o_axi_bvalid),
    .i_axi_bready  (i_axi_bready),
    .i_axi_araddr  (i_axi_araddr),
    .i_axi_arvalid (i_axi_arvalid),
    .o_axi_arready (o_axi_arready),
    .o_axi_rdata   (o_axi_rdata),
    .o_axi_rresp   (o_axi_rresp),
    .o_axi_rvalid  (o_axi_rvalid),
    .i_axi_rready  (i_axi_rready),
    .o_irq_ch      (o_irq_ch),
    .o_irq         (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called just after a posedge; fc is the edge count at which the handshake fired.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output int unsigned fc);
    int unsigned n;
    i_axi_awaddr = a; i_axi_wdata = d; i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
    #1;
    n = 0;
    while (!o_axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_axi_awready) begin
      checks++; errors++;
      $display("FAIL awready_timeout addr %h got 0 exp 1", a);
    end
    @(posedge clk); #1;
    fc = cyc;
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    n = 0;
    while (!o_axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_axi_bvalid) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout addr %h got 0 exp 1", a);
    end
    resp = o_axi_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int unsigned fc);
    int unsigned n;
    i_axi_araddr = a; i_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!o_axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_axi_arready) begin
      checks++; errors++;
      $display("FAIL arready_timeout addr %h got 0 exp 1", a);
    end
    @(posedge clk); #1;
    fc = cyc;
    i_axi_arvalid = 1'b0;
    n = 0;
    while (!o_axi_rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_axi_rvalid) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout addr %h got 0 exp 1", a);
    end
    d = o_axi_rdata; resp = o_axi_rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int unsigned fc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_irq, o_irq_ch, o_axi_bvalid, o_axi_rvalid, o_axi_bresp, o_axi_rresp, o_axi_rdata} !== '0)
      begin errors++; $display("FAIL reset_outputs got irq %b ch %b bv %b rv %b rdata %h exp all 0",
                               o_irq, o_irq_ch, o_axi_bvalid, o_axi_rvalid, o_axi_rdata); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    axi_read(12'h100, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
    axi_read(12'h020, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl2 got %h exp 0", d); end
  endtask

  task automatic test_periodic();
    logic [31:0] d; logic [1:0] r; int unsigned fc, wc, n;
    axi_write(12'h004, 32'd0, r, fc);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL ch0_bresp got %b exp 00", r); end
    axi_write(12'h008, 32'd4, r, fc);
    axi_write(12'h000, 32'h5, r, wc);
    n = 0;
    while (!o_irq && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (cyc - wc != 5) begin errors++; $display("FAIL ch0_irq_latency got %0d exp 5", cyc - wc); end
    checks++;
    if (o_irq_ch !== 4'b0001) begin errors++; $display("FAIL ch0_irq_ch got %b exp 0001", o_irq_ch); end
    for (int i = 0; i < 5; i++) begin
      axi_read(12'h00C, d, r, fc);
      checks++;
      if (d !== 32'((fc - 1 - wc) % 5))
        begin errors++; $display("FAIL ch0_count got %0d exp %0d", d, (fc - 1 - wc) % 5); end
    end
    // W1C landing exactly on a match edge: the set must win.
    while (((cyc + 1 - wc) % 5) != 0) begin @(posedge clk); #1; end
    axi_write(12'h100, 32'h1, r, fc);
    checks++; if (o_irq !== 1'b1) begin errors++; $display("FAIL w1c_vs_set_irq got %b exp 1", o_irq); end
    axi_read(12'h100, d, r, fc);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL w1c_vs_set_status got %h exp 1", d); end
    while (((cyc + 1 - wc) % 5) != 2) begin @(posedge clk); #1; end
    axi_write(12'h100, 32'h1, r, fc);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL w1c_clear_irq got %b exp 0", o_irq); end
    axi_read(12'h100, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear_status got %h exp 0", d); end
    axi_write(12'h000, 32'h0, r, fc);
    axi_write(12'h100, 32'hF, r, fc);
    checks++; if (o_irq !== 1'b0) begin errors++; $display("FAIL ch0_off_irq got %b exp 0", o_irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d; logic [1:0] r; int unsigned fc, wc, n;
    axi_write(12'h014, 32'd3, r, fc);
    axi_write(12'h018, 32'd2, r, fc);
    axi_write(12'h010, 32'h7, r, wc);
    n = 0;
    while (!o_irq_ch[1] && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (cyc - wc != 12) begin errors++; $display("FAIL ch1_match_latency got %0d exp 12", cyc - wc); end
    checks++;
    if (o_irq_ch !== 4'b0010) begin errors++; $display("FAIL ch1_irq_ch got %b exp 0010", o_irq_ch); end
    axi_read(12'h010, d, r, fc);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL ch1_ctrl got %h exp 6", d); end
    axi_read(12'h01C, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ch1_count got %h exp 0", d); end
    repeat (20) @(posedge clk);
    #1;
    axi_read(12'h01C, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ch1_count_hold got %h exp 0", d); end
    axi_write(12'h100, 32'h2, r, fc);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (o_irq_ch !== 4'b0000) begin errors++; $display("FAIL ch1_single got %b exp 0000", o_irq_ch); end
  endtask

  task automatic test_decode_err();
    logic [31:0] d; logic [1:0] r; int unsigned fc;
    axi_read(12'h040, d, r, fc);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL rd_040_resp got %b exp 10", r); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_040_data got %h exp 0", d); end
    axi_read(12'h108, d, r, fc);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL rd_108_resp got %b exp 10", r); end
    axi_write(12'h048, 32'hAB, r, fc);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_048_resp got %b exp 10", r); end
    axi_read(12'h008, d, r, fc);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL wr_048_alias got %h exp 4", d); end
    axi_write(12'h104, 32'hF, r, fc);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_104_resp got %b exp 10", r); end
    axi_read(12'h018, d, r, fc);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL ch1_cmp_kept got %h exp 2", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int unsigned fc, n;
    i_axi_bready = 1'b0;
    i_axi_awaddr = 12'h034; i_axi_wdata = 32'd7; i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    i_axi_awaddr = 12'h038; i_axi_wdata = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_axi_bvalid !== 1'b1 || o_axi_awready !== 1'b0)
        begin errors++; $display("FAIL bp_hold bvalid %b awready %b exp 1 0", o_axi_bvalid, o_axi_awready); end
    end
    i_axi_bready = 1'b1;
    n = 0;
    while (!o_axi_awready && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    checks++; if (o_axi_bvalid !== 1'b1) begin errors++; $display("FAIL bp_second_bvalid got %b exp 1", o_axi_bvalid); end
    @(posedge clk); #1;
    axi_read(12'h034, d, r, fc);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL bp_first_data got %h exp 7", d); end
    axi_read(12'h038, d, r, fc);
    checks++; if (d !== 32'd9) begin errors++; $display("FAIL bp_second_data got %h exp 9", d); end
    i_axi_rready = 1'b0;
    i_axi_araddr = 12'h038; i_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    i_axi_araddr = 12'h034;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_axi_rvalid !== 1'b1 || o_axi_rdata !== 32'd9 || o_axi_arready !== 1'b0)
        begin errors++; $display("FAIL rd_hold rvalid %b rdata %h arready %b exp 1 9 0",
                                 o_axi_rvalid, o_axi_rdata, o_axi_arready); end
    end
    i_axi_arvalid = 1'b0;
    i_axi_rready = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rd_release got %b exp 0", o_axi_rvalid); end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] d, e; logic [1:0] r; int unsigned fc, wc, k;
    axi_write(12'h024, 32'd0, r, fc);
    axi_write(12'h028, 32'hFFFF_FFFF, r, fc);
    axi_write(12'h02C, 32'hFFFF_FFFE, r, fc);
    axi_write(12'h020, 32'h5, r, wc);
    for (int i = 0; i < 2; i++) begin
      axi_read(12'h02C, d, r, fc);
      k = fc - 1 - wc;
      e = (k < 2) ? 32'hFFFF_FFFE + k : 32'(k - 2);
      checks++; if (d !== e) begin errors++; $display("FAIL ch2_wrap_count got %h exp %h", d, e); end
      if (i == 0) begin
        axi_read(12'h100, d, r, fc);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL ch2_status got %h exp 4", d); end
        checks++;
        if (o_irq_ch !== 4'b0100 || o_irq !== 1'b1)
          begin errors++; $display("FAIL ch2_irq got %b %b exp 0100 1", o_irq_ch, o_irq); end
      end
    end
    i_axi_bready = 1'b0; i_axi_rready = 1'b0;
    i_axi_awaddr = 12'h038; i_axi_wdata = 32'd5; i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1;
    i_axi_araddr = 12'h02C; i_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0; i_axi_arvalid = 1'b0;
    checks++;
    if (o_axi_bvalid !== 1'b1 || o_axi_rvalid !== 1'b1)
      begin errors++; $display("FAIL pre_reset_pending bv %b rv %b exp 1 1", o_axi_bvalid, o_axi_rvalid); end
    #2; rst = 1'b1; #1;
    checks++;
    if ({o_axi_bvalid, o_axi_rvalid, o_irq, o_irq_ch, o_axi_rdata} !== '0)
      begin errors++; $display("FAIL mid_reset bv %b rv %b irq %b ch %b rdata %h exp all 0",
                               o_axi_bvalid, o_axi_rvalid, o_irq, o_irq_ch, o_axi_rdata); end
    @(negedge clk); rst = 1'b0; i_axi_bready = 1'b1; i_axi_rready = 1'b1;
    @(posedge clk); #1;
    axi_read(12'h02C, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_count got %h exp 0", d); end
    axi_read(12'h020, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_ctrl got %h exp 0", d); end
    axi_read(12'h038, d, r, fc);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_cmp3 got %h exp 0", d); end
  endtask

  initial begin
    rst = 1'b1;
    i_axi_awaddr = '0; i_axi_awvalid = 1'b0; i_axi_wdata = '0; i_axi_wvalid = 1'b0;
    i_axi_bready = 1'b1; i_axi_araddr = '0; i_axi_arvalid = 1'b0; i_axi_rready = 1'b1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_decode_err();
    test_back_to_back();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
